config_stream_loader: RTL

Serial-to-parallel configuration master that drives the fabric-wide `config_addr`/`config_data` bus read by every PE tile. It receives the bitstream one bit per cycle, assembles 64-bit words (address high, data low), and presents each word on the bus for exactly one cycle. Between words the bus holds a parked address that no tile decodes. It sits at the top level between the off-chip programming pin and the tile array.

---
 rtl/config_stream_loader.sv | 124 ++++++++++++
 1 files changed

// File: rtl/config_stream_loader.sv
// Serial bitstream to fabric config bus master; one-cycle writes, parked bus otherwise.
// Optional per-word even parity: define CONFIG_STREAM_LOADER_PARITY_EN.
module config_stream_loader #(
  parameter logic [31:0] PARK_ADDR = 32'hFFFF_FFFF,
  parameter logic [63:0] END_WORD  = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        bit_ready,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        config_write,
  output logic        busy,
  output logic        done,
  output logic [15:0] word_count,
  output logic        parity_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

`ifdef CONFIG_STREAM_LOADER_PARITY_EN
  localparam int          SW   = 64;
  localparam logic [6:0]  LAST = 7'd64;
`else
  localparam int          SW   = 63;
  localparam logic [6:0]  LAST = 7'd63;
`endif

  state_t          state_q, state_d;
  logic [SW-1:0]   shreg_q, shreg_d;
  logic [6:0]      cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic            wr_q, wr_d;
  logic [15:0]     wcnt_q, wcnt_d;
  logic            perr_q, perr_d;
  logic [63:0]     word;
  logic            par_ok;
  logic            accept;

  // The final bit of a word is consumed straight from bit_in.
`ifdef CONFIG_STREAM_LOADER_PARITY_EN
  assign word   = shreg_q;
  assign par_ok = ~^{shreg_q, bit_in};
`else
  assign word   = {shreg_q, bit_in};
  assign par_ok = 1'b1;
`endif

  assign accept = (state_q == LOAD) && bit_valid;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    addr_d  = PARK_ADDR;
    data_d  = '0;
    wr_d    = 1'b0;
    wcnt_d  = wcnt_q;
    perr_d  = perr_q;
    if (start) begin
      state_d = LOAD;
      shreg_d = '0;
      cnt_d   = '0;
      wcnt_d  = '0;
      perr_d  = 1'b0;
    end else if (accept) begin
      shreg_d = {shreg_q[SW-2:0], bit_in};
      cnt_d   = cnt_q + 7'd1;
      if (cnt_q == LAST) begin
        cnt_d = '0;
        if (!par_ok) begin
          perr_d = 1'b1;
        end else if (word == END_WORD) begin
          state_d = DONE;
        end else begin
          addr_d = word[63:32];
          data_d = word[31:0];
          wr_d   = 1'b1;
          if (wcnt_q != 16'hFFFF) wcnt_d = wcnt_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      addr_q  <= PARK_ADDR;
      data_q  <= '0;
      wr_q    <= 1'b0;
      wcnt_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      wcnt_q  <= wcnt_d;
      perr_q  <= perr_d;
    end
  end

  assign bit_ready    = (state_q == LOAD);
  assign busy         = (state_q == LOAD);
  assign done         = (state_q == DONE);
  assign config_addr  = addr_q;
  assign config_data  = data_q;
  assign config_write = wr_q;
  assign word_count   = wcnt_q;
  assign parity_err   = perr_q;

endmodule
